// File: rtl/divider_control.sv
// rtl/divider_control.sv - sequencer for the unsigned restoring divider
// Registered control outputs; only the DECIDE-cycle Remainder code and ALU select follow sign_flag.
module divider_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             divisor_zero,
  input  logic             sign_flag,
  output logic [1:0]       w_ctrl_reg2,
  output logic             alu_sub,
  output logic             rem_we,
  output logic             divisor_we,
  output logic             busy,
  output logic             rdy,
  output logic             div_by_zero,
  output logic [CNT_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SUB,
    S_DECIDE,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [1:0]       wctrl_q;
  logic             alu_sub_q;
  logic             rem_we_q;
  logic             divisor_we_q;
  logic             busy_q;
  logic             rdy_q;
  logic             dbz_q;
  logic [CNT_W-1:0] cnt_q;

  // Each branch sets the outputs that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wctrl_q      <= 2'b00;
      alu_sub_q    <= 1'b0;
      rem_we_q     <= 1'b0;
      divisor_we_q <= 1'b0;
      busy_q       <= 1'b0;
      rdy_q        <= 1'b0;
      dbz_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      wctrl_q      <= 2'b00;
      alu_sub_q    <= 1'b0;
      rem_we_q     <= 1'b0;
      divisor_we_q <= 1'b0;
      busy_q       <= 1'b0;
      rdy_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (divisor_zero) begin
              state_q <= S_DONE;
              dbz_q   <= 1'b1;
              rdy_q   <= 1'b1;
            end else begin
              state_q      <= S_LOAD;
              dbz_q        <= 1'b0;
              cnt_q        <= '0;
              rem_we_q     <= 1'b1;
              divisor_we_q <= 1'b1;
              busy_q       <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          state_q   <= S_SUB;
          cnt_q     <= '0;
          wctrl_q   <= 2'b01;
          alu_sub_q <= 1'b1;
          rem_we_q  <= 1'b1;
          busy_q    <= 1'b1;
        end
        S_SUB: begin
          state_q  <= S_DECIDE;
          rem_we_q <= 1'b1;
          busy_q   <= 1'b1;
        end
        S_DECIDE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q <= S_DONE;
            rdy_q   <= 1'b1;
          end else begin
            state_q   <= S_SUB;
            wctrl_q   <= 2'b01;
            alu_sub_q <= 1'b1;
            rem_we_q  <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // DECIDE: sign 0 keeps the difference and shifts in 1, sign 1 restores and shifts in 0.
  assign w_ctrl_reg2 = (state_q == S_DECIDE) ? {1'b1, sign_flag} : wctrl_q;
  assign alu_sub     = (state_q == S_DECIDE) ? ~sign_flag : alu_sub_q;
  assign rem_we      = rem_we_q;
  assign divisor_we  = divisor_we_q;
  assign busy        = busy_q;
  assign rdy         = rdy_q;
  assign div_by_zero = dbz_q;
  assign iter_cnt    = cnt_q;

endmodule

// File: tb/tb_divider_control.sv
// tb/tb_divider_control.sv - directed self-checking bench for divider_control
// Includes a negedge Remainder/Divisor datapath model driven by the controller outputs.
module tb_divider_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        divisor_zero;
  logic        sign_flag;
  logic [1:0]  w_ctrl;
  logic        alu_sub;
  logic        rem_we;
  logic        divisor_we;
  logic        busy;
  logic        rdy;
  logic        div_by_zero;
  logic [5:0]  iter_cnt;

  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] divisor_m = '0;
  logic [64:0] rem_m = '0;
  int          sf_mode;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  divider_control #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .divisor_zero(divisor_zero),
    .sign_flag(sign_flag), .w_ctrl_reg2(w_ctrl), .alu_sub(alu_sub),
    .rem_we(rem_we), .divisor_we(divisor_we), .busy(busy), .rdy(rdy),
    .div_by_zero(div_by_zero), .iter_cnt(iter_cnt)
  );

  // sf_mode: 0 = datapath sign, 1 = forced 0, 2 = forced 1
  assign sign_flag = (sf_mode == 0) ? rem_m[64] : (sf_mode == 2);

  always @(negedge clk) begin
    if (divisor_we) divisor_m <= divisor;
    if (rem_we) begin
      case (w_ctrl)
        2'b00: rem_m <= {32'b0, dividend, 1'b0};
        2'b01: rem_m[64:32] <= rem_m[64:32] - {1'b0, divisor_m};
        2'b10: rem_m <= {rem_m[63:0], 1'b1};
        2'b11: rem_m <= {rem_m[63:32] + divisor_m, rem_m[31:0], 1'b0};
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] all_outs();
    return {w_ctrl, alu_sub, rem_we, divisor_we, busy, rdy, div_by_zero, iter_cnt};
  endfunction

  task automatic run_div(input logic [31:0] dvd, input logic [31:0] dvs, input int mode,
                         input bit repulse, output int n10, output int n11);
    int bad;
    int rdys;
    int rdy_at;
    logic sgn;
    logic [1:0] exp_code;
    dividend = dvd; divisor = dvs; divisor_zero = 1'b0; sf_mode = mode;
    start = 1'b1;
    tick();
    n10 = 0; n11 = 0; bad = 0; rdys = 0; rdy_at = -1;
    check("load_ctrl", {w_ctrl, rem_we, divisor_we, busy, rdy}, {2'b00, 4'b1110});
    check("load_cnt", iter_cnt, 0);
    start = 1'b0;
    tick();
    for (int c = 2; c <= 66; c++) begin
      if (rdy) begin rdys++; rdy_at = c; end
      if (c <= 65) begin
        if (!busy || !rem_we || divisor_we) bad++;
        if (c % 2 == 0) begin
          if (w_ctrl !== 2'b01 || alu_sub !== 1'b1) bad++;
        end else begin
          sgn = (mode == 0) ? rem_m[64] : (mode == 2);
          exp_code = sgn ? 2'b11 : 2'b10;
          if (w_ctrl !== exp_code || alu_sub !== !sgn) bad++;
          if (w_ctrl === 2'b10) n10++;
          if (w_ctrl === 2'b11) n11++;
        end
      end
      start = repulse && (c == 10 || c == 66);
      if (c < 66) tick();
    end
    check("rdy_cycle", rdy_at, 66);
    check("done_cnt", iter_cnt, 32);
    check("done_dbz", div_by_zero, 0);
    check("done_busy_we", {busy, rem_we}, 0);
    tick();
    if (rdy) rdys++;
    check("idle67", {busy, rdy, rem_we}, 0);
    start = 1'b0;
    tick();
    if (rdy) rdys++;
    check("idle68", {busy, rem_we, divisor_we, rdy}, 0);
    check("rdy_pulses", rdys, 1);
    check("seq_bad", bad, 0);
  endtask

  initial begin
    int n10;
    int n11;
    int lowb;
    int rdy1;
    int rdy2;
    int nrdy;
    rst = 1'b0; start = 1'b0; divisor_zero = 1'b0;
    dividend = '0; divisor = '0; sf_mode = 0;
    repeat (2) tick();
    check("reset_outs", all_outs(), 0);
    rst = 1'b1;
    tick();

    run_div(32'd100, 32'd7, 0, 1'b0, n10, n11);
    check("quot_100_7", rem_m[31:0], 14);
    check("rem_100_7", rem_m[64:33], 2);

    run_div(32'd100, 32'd7, 1, 1'b0, n10, n11);
    check("forced0_n10", n10, 32);
    check("forced0_n11", n11, 0);

    run_div(32'd100, 32'd7, 2, 1'b0, n10, n11);
    check("forced1_n11", n11, 32);
    check("forced1_n10", n10, 0);

    sf_mode = 0; divisor_zero = 1'b1; start = 1'b1;
    tick();
    check("dz_rdy_dbz", {rdy, div_by_zero}, 2'b11);
    check("dz_no_we", {rem_we, divisor_we, busy}, 0);
    check("dz_cnt_hold", iter_cnt, 32);
    start = 1'b0; divisor_zero = 1'b0;
    tick();
    check("dz_after", {rdy, rem_we, divisor_we, busy}, 0);

    run_div(32'd12345, 32'd5, 0, 1'b1, n10, n11);
    check("quot_repulse", rem_m[31:0], 2469);
    check("rem_repulse", rem_m[64:33], 0);

    dividend = 32'd100; divisor = 32'd7; sf_mode = 0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 20; c++) tick();
    rst = 1'b0;
    tick();
    check("midreset_outs", all_outs(), 0);
    rst = 1'b1;
    tick();
    check("midreset_idle", {busy, rem_we, rdy}, 0);
    run_div(32'd100, 32'd7, 0, 1'b0, n10, n11);
    check("quot_after_rst", rem_m[31:0], 14);

    dividend = 32'd1000; divisor = 32'd3; sf_mode = 0; start = 1'b1;
    tick();
    lowb = 0; rdy1 = -1; rdy2 = -1; nrdy = 0;
    for (int c = 1; c <= 134; c++) begin
      if (rdy) begin
        nrdy++;
        if (rdy1 < 0) rdy1 = c; else rdy2 = c;
      end
      if (!busy) lowb++;
      if (c == 134) start = 1'b0;
      tick();
    end
    check("held_rdy_count", nrdy, 2);
    check("held_rdy1", rdy1, 66);
    check("held_rdy2", rdy2, 133);
    check("held_busy_low", lowb, 4);
    check("held_stop", {busy, rem_we}, 0);
    check("quot_1000_3", rem_m[31:0], 333);
    check("rem_1000_3", rem_m[64:33], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
